core_if: RTL and testbench

- Instruction fetch stage of the RISC-V core; upstream producer for the decode stage.
- Generates the fetch PC, issues in-order reads on a simple instruction bus, and predecodes returned instructions for static branch prediction.
- Buffers fetched instructions and hands them to decode over a valid/ready handshake.
- Honours redirect/flush requests from the execute stage.

---
 rtl/core_if.sv | 242 ++++++++++++++++++++++++
 tb/tb_core_if.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_if.sv
// ----------------------------------------------------------------------------
// core_if - instruction fetch stage
//
// Generates the fetch PC, issues in-order reads on a simple instruction bus,
// predecodes returned words for static branch prediction (JAL and backward
// conditional branches are predicted taken) and buffers fetched instructions
// for the decode stage behind a valid/ready handshake. A redirect from the
// execute stage (flush_en) has the highest priority.
//
// Ports
//   clk          core clock
//   rest         asynchronous active-high reset
//   ibus_addr    read address (word aligned, equals the fetch PC)
//   ibus_valid   read request
//   ibus_ready   request accepted when ibus_valid && ibus_ready
//   ibus_rvalid  read data valid, responses return in request order
//   ibus_rdata   instruction word
//   flush_en     execute-stage redirect/flush
//   flush_pc     redirect target
//   if_istr      instruction to decode
//   if_pc        PC of if_istr
//   if_valid     if_istr/if_pc/if_jump valid
//   if_jump      entry was predicted taken and fetch already redirected
//   if_ready     decode accepts; transfer on if_valid && if_ready
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module core_if #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rest,
    output logic [31:0] ibus_addr,
    output logic        ibus_valid,
    input  logic        ibus_ready,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    input  logic        flush_en,
    input  logic [31:0] flush_pc,
    output logic [31:0] if_istr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        if_jump,
    input  logic        if_ready
);

    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] drop_cnt_reg, drop_cnt_next;

    logic [PW-1:0] buf_rd_reg, buf_wr_reg;
    logic [CW-1:0] buf_count_reg;
    logic [PW-1:0] pcq_rd_reg, pcq_wr_reg;

    // Per-entry storage lives in the generate blocks; these arrays expose it
    // for the read muxes.
    logic [31:0] buf_istr_arr [FIFO_DEPTH];
    logic [31:0] buf_pc_arr   [FIFO_DEPTH];
    logic        buf_jump_arr [FIFO_DEPTH];
    logic [31:0] pcq_arr      [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Bus request side
    // ------------------------------------------------------------------
    logic credit;
    logic accept;

    // Every buffered entry plus every read in flight holds one credit, so a
    // response can always be stored without back-pressuring the bus.
    assign credit     = ({1'b0, buf_count_reg} + {1'b0, outstanding_reg}) < {1'b0, DEPTH_C};
    assign ibus_valid = !rest && !flush_en && credit;
    assign ibus_addr  = fetch_pc_reg;
    assign accept     = ibus_valid && ibus_ready;

    // ------------------------------------------------------------------
    // Response side and predecode
    // ------------------------------------------------------------------
    logic        resp;
    logic        keep;
    logic        push;
    logic        pop;
    logic [31:0] resp_pc;
    logic        is_jal;
    logic        is_bwd_br;
    logic        predict;
    logic [31:0] jal_off;
    logic [31:0] br_off;
    logic [31:0] target;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp    = ibus_rvalid && (outstanding_reg != '0);
    assign resp_pc = pcq_arr[pcq_rd_reg];
    assign keep    = resp && (drop_cnt_reg == '0);

    assign is_jal    = (ibus_rdata[6:0] == OP_JAL);
    assign is_bwd_br = (ibus_rdata[6:0] == OP_BRANCH) && ibus_rdata[31];

    assign jal_off = {{11{ibus_rdata[31]}}, ibus_rdata[31], ibus_rdata[19:12],
                      ibus_rdata[20], ibus_rdata[30:21], 1'b0};
    assign br_off  = {{19{ibus_rdata[31]}}, ibus_rdata[31], ibus_rdata[7],
                      ibus_rdata[30:25], ibus_rdata[11:8], 1'b0};
    assign target  = resp_pc + (is_jal ? jal_off : br_off);

    assign predict = keep && (is_jal || is_bwd_br);
    assign push    = keep && !flush_en;

    // ------------------------------------------------------------------
    // Decode side
    // ------------------------------------------------------------------
    assign if_valid = (buf_count_reg != '0);
    assign pop      = if_valid && if_ready && !flush_en;
    assign if_istr  = buf_istr_arr[buf_rd_reg];
    assign if_pc    = buf_pc_arr[buf_rd_reg];
    assign if_jump  = buf_jump_arr[buf_rd_reg];

    // ------------------------------------------------------------------
    // Next-state logic for fetch PC and drop counter
    // ------------------------------------------------------------------
    assign outstanding_next = outstanding_reg + CW'(accept) - CW'(resp);

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        drop_cnt_next = drop_cnt_reg;

        if (resp && (drop_cnt_reg != '0)) begin
            drop_cnt_next = drop_cnt_reg - 1'b1;
        end
        if (accept) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
        // Redirects discard everything still in flight after this cycle,
        // including a request accepted in this very cycle.
        if (predict) begin
            fetch_pc_next = target;
            drop_cnt_next = outstanding_next;
        end
        if (flush_en) begin
            fetch_pc_next = flush_pc;
            drop_cnt_next = outstanding_next;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            pcq_rd_reg      <= '0;
            pcq_wr_reg      <= '0;
            buf_rd_reg      <= '0;
            buf_wr_reg      <= '0;
            buf_count_reg   <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;

            // The PC queue tracks bus reads and is not affected by a flush:
            // the dropped responses still arrive and must be matched.
            if (accept) begin
                pcq_wr_reg <= pcq_wr_reg + 1'b1;
            end
            if (resp) begin
                pcq_rd_reg <= pcq_rd_reg + 1'b1;
            end

            if (flush_en) begin
                buf_rd_reg    <= '0;
                buf_wr_reg    <= '0;
                buf_count_reg <= '0;
            end else begin
                if (push) begin
                    buf_wr_reg <= buf_wr_reg + 1'b1;
                end
                if (pop) begin
                    buf_rd_reg <= buf_rd_reg + 1'b1;
                end
                buf_count_reg <= buf_count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-entry storage: instruction buffer and in-order PC queue
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [31:0] istr_reg;
            logic [31:0] pc_reg;
            logic        jump_reg;
            logic [31:0] req_pc_reg;

            always_ff @(posedge clk or posedge rest) begin
                if (rest) begin
                    istr_reg   <= '0;
                    pc_reg     <= '0;
                    jump_reg   <= 1'b0;
                    req_pc_reg <= '0;
                end else begin
                    if (push && (buf_wr_reg == PW'(gi))) begin
                        istr_reg <= ibus_rdata;
                        pc_reg   <= resp_pc;
                        jump_reg <= predict;
                    end
                    if (accept && (pcq_wr_reg == PW'(gi))) begin
                        req_pc_reg <= fetch_pc_reg;
                    end
                end
            end

            assign buf_istr_arr[gi] = istr_reg;
            assign buf_pc_arr[gi]   = pc_reg;
            assign buf_jump_arr[gi] = jump_reg;
            assign pcq_arr[gi]      = req_pc_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Simulation checks: credit accounting must make overflow impossible
    // ------------------------------------------------------------------
    a_buf_no_overflow : assert property (@(posedge clk) disable iff (rest)
        (push && !pop) |-> (buf_count_reg < DEPTH_C));

    a_pcq_no_overflow : assert property (@(posedge clk) disable iff (rest)
        (accept && !resp) |-> (outstanding_reg < DEPTH_C));

endmodule

// File: tb/tb_core_if.sv
`timescale 1ns/1ps

module tb_core_if;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          D   = 2;

    logic        clk;
    logic        rest;
    logic [31:0] ibus_addr;
    logic        ibus_valid;
    logic        ibus_ready;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        flush_en;
    logic [31:0] flush_pc;
    logic [31:0] if_istr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        if_jump;
    logic        if_ready;

    core_if #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rest        (rest),
        .ibus_addr   (ibus_addr),
        .ibus_valid  (ibus_valid),
        .ibus_ready  (ibus_ready),
        .ibus_rvalid (ibus_rvalid),
        .ibus_rdata  (ibus_rdata),
        .flush_en    (flush_en),
        .flush_pc    (flush_pc),
        .if_istr     (if_istr),
        .if_pc       (if_pc),
        .if_valid    (if_valid),
        .if_jump     (if_jump),
        .if_ready    (if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } bus_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] istr;
        logic        jump;
    } exp_t;

    bus_t bq[$];   // reads accepted by the bus model, in order
    exp_t sb[$];   // expected decode-side deliveries

    int          checks;
    int          errors;
    int          cyc;
    int          lat;
    int          accepts;
    int          delivered;
    logic        late_rvalid;
    logic        rand_bus;
    logic        rand_dec;
    logic [31:0] model_pc;

    // Program image: a JAL loop at 0x1F8..0x200, a forward branch and JALR
    // at 0x300/0x304, a backward branch at 0x30C; everything else is ALU ops.
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0200: return 32'hFF9F_F06F;  // jal  x0, -8
            32'h0000_0300: return 32'h0000_0863;  // beq  x0, x0, +16
            32'h0000_0304: return 32'h0000_8067;  // jalr x0, 0(x1)
            32'h0000_030C: return 32'hFE00_0AE3;  // beq  x0, x0, -12
            default:       return {a[19:0], 5'd1, 7'b0010011};
        endcase
    endfunction

    // Program-flow model: which PCs decode should see, in order.
    task automatic topup(input int n);
        exp_t e;
        while (sb.size() < n) begin
            e.pc   = model_pc;
            e.istr = mem(model_pc);
            case (model_pc)
                32'h0000_0200: begin e.jump = 1'b1; model_pc = 32'h0000_01F8; end
                32'h0000_030C: begin e.jump = 1'b1; model_pc = 32'h0000_0300; end
                default:       begin e.jump = 1'b0; model_pc = model_pc + 32'd4; end
            endcase
            sb.push_back(e);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus/decode cycle, entered and left at the falling edge.
    task automatic tick();
        bus_t b;
        if (late_rvalid) begin
            ibus_rvalid = 1'b1;
            ibus_rdata  = 32'h0000_006F;  // jal x0, 0: would redirect if taken
            late_rvalid = 1'b0;
        end else if (bq.size() > 0 && bq[0].due <= cyc) begin
            ibus_rvalid = 1'b1;
            ibus_rdata  = mem(bq[0].addr);
            void'(bq.pop_front());
        end else begin
            ibus_rvalid = 1'b0;
            ibus_rdata  = $urandom;
        end
        ibus_ready = rand_bus ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rand_dec && !flush_en) if_ready = 1'($urandom_range(0, 1));
        #1;
        if (flush_en) chk("flush_no_request", {31'd0, ibus_valid}, 32'd0);
        if (ibus_valid && ibus_ready) begin
            b.addr = ibus_addr;
            b.due  = cyc + lat;
            bq.push_back(b);
            accepts++;
        end
        if (if_valid) begin
            if (sb.size() == 0) begin
                if (if_ready) begin
                    checks++;
                    assert (sb.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_delivery observed pc=%h expected none", if_pc);
                    end
                end
            end else begin
                chk("head_pc",   if_pc,   sb[0].pc);
                chk("head_istr", if_istr, sb[0].istr);
                chk("head_jump", {31'd0, if_jump}, {31'd0, sb[0].jump});
                if (if_ready) begin
                    $display("deliver pc=%h istr=%h jump=%0d", if_pc, if_istr, if_jump);
                    void'(sb.pop_front());
                    delivered++;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        int target;
        target = delivered + n;
        topup(n + 4);
        for (int i = 0; i < 400 && delivered < target; i++) tick();
        checks++;
        assert (delivered >= target) else begin
            errors++;
            $error("FAIL run_timeout observed=%0d expected=%0d deliveries", delivered, target);
        end
    endtask

    // Flush in a cycle where a read response is arriving.
    task automatic do_flush(input logic [31:0] pc);
        bit found;
        found = 1'b0;
        topup(8);
        for (int w = 0; w < 40 && !found; w++) begin
            if (bq.size() > 0 && bq[0].due <= cyc) found = 1'b1;
            else tick();
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL flush_setup observed=no_response expected=response_due");
        end
        if_ready = 1'b0;
        flush_en = 1'b1;
        flush_pc = pc;
        tick();
        flush_en = 1'b0;
        sb.delete();
        model_pc = pc;
        topup(16);
        $display("flush to %h", pc);
        chk("flush_if_valid_next", {31'd0, if_valid}, 32'd0);
        chk("flush_next_addr", ibus_addr, pc);
        if_ready = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ibus_valid"}, {31'd0, ibus_valid}, 32'd0);
        chk({tag, "_if_valid"},   {31'd0, if_valid},   32'd0);
        chk({tag, "_if_istr"},    if_istr,             32'd0);
        chk({tag, "_if_pc"},      if_pc,               32'd0);
        chk({tag, "_if_jump"},    {31'd0, if_jump},    32'd0);
        chk({tag, "_ibus_addr"},  ibus_addr,           RPC);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; lat = 1; accepts = 0; delivered = 0;
        late_rvalid = 1'b0; rand_bus = 1'b0; rand_dec = 1'b0; model_pc = RPC;
        rest = 1'b1; ibus_ready = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
        flush_en = 1'b0; flush_pc = '0; if_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");

        // First request and first-delivery latency (k = 1)
        rest = 1'b0;
        #1;
        chk("first_req_valid", {31'd0, ibus_valid}, 32'd1);
        chk("first_req_addr",  ibus_addr, RPC);
        model_pc = RPC;
        topup(16);
        tick();
        chk("latency_cycle1_if_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("latency_cycle2_if_valid", {31'd0, if_valid}, 32'd1);
        chk("latency_cycle2_if_pc", if_pc, RPC);
        run(10);

        // Decode stall: bounded fetching, head holds, then in-order drain
        begin
            int a0;
            a0 = accepts;
            if_ready = 1'b0;
            repeat (5) tick();
            chk("stall_fetch_bound", {31'd0, (accepts - a0) <= D}, 32'd1);
            chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
            if_ready = 1'b1;
            run(8);
        end

        // JAL x0,-8 at 0x200 with multiple reads in flight
        lat = 3;
        do_flush(32'h0000_01F0);
        run(12);

        // Flush to 0x400 with a response returning in the flush cycle
        do_flush(32'h0000_0400);
        run(6);

        // Forward branch / JALR not predicted; backward branch predicted;
        // randomised bus and decode back-pressure
        lat = 2;
        rand_bus = 1'b1;
        rand_dec = 1'b1;
        do_flush(32'h0000_02F8);
        run(16);
        rand_bus = 1'b0;
        rand_dec = 1'b0;
        if_ready = 1'b1;

        // Reset asserted mid-transfer with a read outstanding
        lat = 3;
        run(3);
        for (int w = 0; w < 20 && bq.size() == 0; w++) tick();
        chk("mid_reset_setup_outstanding", {31'd0, bq.size() > 0}, 32'd1);
        #2 rest = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        bq.delete();
        sb.delete();
        ibus_rvalid = 1'b0;
        @(negedge clk);
        repeat (2) tick();
        rest = 1'b0;
        late_rvalid = 1'b1;
        model_pc = RPC;
        topup(12);
        run(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
